// File: rtl/jtframe_ba_fetch.sv
// jtframe_ba_fetch: single-line read cache in front of one SDRAM controller
// bank read port. A reader word request hits the buffered BURST-word line
// with one cycle of latency; a miss fetches the aligned line through the
// rd/ack/dst/dok/rdy handshake and then reports ok.
module jtframe_ba_fetch #(
  parameter int AW    = 22,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inval,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  output logic          ok,
  output logic [15:0]   dout,
  output logic          err,
  output logic [AW-1:0] ba_addr,
  output logic          ba_rd,
  input  logic          ba_ack,
  input  logic          ba_dst,
  input  logic          ba_dok,
  input  logic          ba_rdy,
  input  logic [15:0]   data_read
);

  localparam int BW = $clog2(BURST);
  // One extra bit so the word counter can saturate at BURST
  localparam int CW = BW + 1;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t            state_reg;
  logic [15:0]       buf_mem [BURST];
  logic [AW-BW-1:0]  tag_reg;
  logic              valid_reg;
  logic              inval_pend_reg;
  logic [CW-1:0]     cnt_reg;

  logic              hit;
  logic              filling;
  logic [CW-1:0]     wr_idx;
  logic [CW-1:0]     wr_idx_inc;
  logic              wr_en;
  logic              last_word;

  assign hit        = valid_reg && (addr[AW-1:BW] == tag_reg);
  assign filling    = (state_reg != IDLE);
  // dst restarts the line at word 0 regardless of what was counted so far
  assign wr_idx     = ba_dst ? '0 : cnt_reg;
  // Words beyond BURST (overlong burst) are dropped rather than wrapping
  assign wr_en      = filling && ba_dok && (wr_idx < CW'(BURST));
  assign wr_idx_inc = (wr_idx == CW'(BURST)) ? wr_idx : wr_idx + 1'b1;
  assign last_word  = filling && ba_dok && ba_rdy;

  // Line buffer write port; data arriving while idle or in reset is ignored
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      buf_mem[wr_idx[BW-1:0]] <= data_read;
    end
  end

  // Request/fill state machine with registered reader and controller outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      ok             <= 1'b0;
      dout           <= 16'h0000;
      err            <= 1'b0;
      ba_rd          <= 1'b0;
      ba_addr        <= '0;
      tag_reg        <= '0;
      valid_reg      <= 1'b0;
      cnt_reg        <= '0;
      inval_pend_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          dout <= buf_mem[addr[BW-1:0]];
          ok   <= cs && hit && !inval;
          if (inval) begin
            valid_reg <= 1'b0;
          end
          if (cs && !hit) begin
            ba_rd          <= 1'b1;
            ba_addr        <= {addr[AW-1:BW], {BW{1'b0}}};
            tag_reg        <= addr[AW-1:BW];
            valid_reg      <= 1'b0;
            cnt_reg        <= '0;
            inval_pend_reg <= 1'b0;
            ok             <= 1'b0;
            state_reg      <= REQ;
          end
        end
        default: begin
          // REQ and FILL share data capture: dok may come with or before ack
          ok <= 1'b0;
          if (state_reg == REQ && ba_ack) begin
            ba_rd     <= 1'b0;
            state_reg <= FILL;
          end
          if (inval) begin
            inval_pend_reg <= 1'b1;
          end
          if (ba_dok) begin
            cnt_reg <= wr_idx_inc;
          end
          if (last_word) begin
            err            <= err | (wr_idx != CW'(BURST - 1));
            valid_reg      <= !inval_pend_reg && !inval;
            inval_pend_reg <= 1'b0;
            ba_rd          <= 1'b0;
            state_reg      <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
